// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 16 x DATA_W general register file, two combinational read
// ports, one synchronous write port, plus a ready/valid dump engine that
// streams every register (index 0..15) to a debug/trace consumer.
//
// Optional build macro: REGFILE_BYPASS_EN
//   When defined, a write in flight (we, legal nonzero waddr) is forwarded to
//   any read port addressing the same register in the same cycle. The dump
//   port never sees forwarded data.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   raddr_a/b, rdata_a/b  read ports (0-cycle latency)
//   we, waddr, wdata      write port (updates at rising edge)
//   dump_start            request to stream all registers (honoured in idle)
//   dump_ready            consumer accepts current beat
//   dump_valid/addr/data  presented beat
//   dump_busy             engine not idle
//   dump_done             one-cycle pulse after the last beat is accepted
module reg_file_2r1w #(
  parameter int unsigned       DATA_W  = 16,
  parameter int unsigned       ADDR_W  = 17,
  parameter int unsigned       SP_REG  = 15,
  parameter logic [DATA_W-1:0] SP_INIT = 16'hFFFE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [3:0]        dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int unsigned NumRegs = 16;

  typedef enum logic [1:0] {StIdle, StSend, StDone} dump_state_e;

  logic [DATA_W-1:0] regs_q [NumRegs];
  dump_state_e       state_q, state_d;
  logic [3:0]        idx_q, idx_d;

  logic              raddr_a_legal, raddr_b_legal, waddr_legal;
  logic              wr_en;
  logic [DATA_W-1:0] arr_a, arr_b;

  // Upper address bits select nothing; any set bit makes the access illegal.
  assign raddr_a_legal = (raddr_a[ADDR_W-1:4] == '0);
  assign raddr_b_legal = (raddr_b[ADDR_W-1:4] == '0);
  assign waddr_legal   = (waddr[ADDR_W-1:4] == '0);

  // Register 0 is never written, so it only ever holds its reset value.
  assign wr_en = we && waddr_legal && (waddr[3:0] != 4'd0);

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= (i == SP_REG) ? SP_INIT : '0;
      end
    end else if (wr_en) begin
      regs_q[waddr[3:0]] <= wdata;
    end
  end

  // Array reads; r0 is forced to zero so it reads 0 even before any reset.
  always_comb begin
    arr_a = '0;
    arr_b = '0;
    if (raddr_a_legal && (raddr_a[3:0] != 4'd0)) arr_a = regs_q[raddr_a[3:0]];
    if (raddr_b_legal && (raddr_b[3:0] != 4'd0)) arr_b = regs_q[raddr_b[3:0]];
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the write in flight so writeback and operand read of the same
  // register can share one instruction cycle.
  always_comb begin
    rdata_a = arr_a;
    rdata_b = arr_b;
    if (wr_en && (raddr_a == waddr)) rdata_a = wdata;
    if (wr_en && (raddr_b == waddr)) rdata_b = wdata;
  end
`else
  always_comb begin
    rdata_a = arr_a;
    rdata_b = arr_b;
  end
`endif

  // ---------------------------------------------------------------------------
  // Dump engine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (dump_start) begin
          state_d = StSend;
          idx_d   = 4'd0;
        end
      end
      StSend: begin
        // Beat holds (valid stays high) until the consumer takes it.
        if (dump_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign dump_valid = (state_q == StSend);
  assign dump_done  = (state_q == StDone);
  assign dump_busy  = (state_q != StIdle);
  assign dump_addr  = idx_q;
  // Live array read, deliberately without forwarding.
  assign dump_data  = (idx_q == 4'd0) ? '0 : regs_q[idx_q];

endmodule
